// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer: sb/sh/sw formatting, FIFO drain, load hazard detect
// Stores are formatted at acceptance, so every queue entry is already a word write ready for memory.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [2:0]               st_funct3,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_err,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     ld_check,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          st_err_q, st_err_d;

  logic [29:0]   entry_addr_q [DEPTH];
  logic [29:0]   entry_addr_d [DEPTH];
  logic [31:0]   entry_data_q [DEPTH];
  logic [31:0]   entry_data_d [DEPTH];
  logic [3:0]    entry_be_q   [DEPTH];
  logic [3:0]    entry_be_d   [DEPTH];

  logic [1:0]    off;
  logic [3:0]    fmt_be;
  logic [31:0]   fmt_wdata;
  logic          fmt_legal;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;
  logic          hit;
  logic [PW-1:0] slot;
  logic          unused_ld_lsbs;

  assign off = st_addr[1:0];

  always_comb begin
    fmt_be    = 4'b0000;
    fmt_wdata = st_data;
    fmt_legal = 1'b0;
    case (st_funct3)
      3'b000: begin
        fmt_be    = 4'b0001 << off;
        fmt_wdata = {4{st_data[7:0]}};
        fmt_legal = 1'b1;
      end
      3'b001: begin
        fmt_be    = off[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{st_data[15:0]}};
        fmt_legal = !off[0];
      end
      3'b010: begin
        fmt_be    = 4'b1111;
        fmt_wdata = st_data;
        fmt_legal = (off == 2'b00);
      end
      default: begin
        fmt_be    = 4'b0000;
        fmt_wdata = st_data;
        fmt_legal = 1'b0;
      end
    endcase
  end

  // No pass-through: a full buffer refuses stores even while the head is popping.
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign st_ready  = !full;
  assign mem_valid = (count_q != '0);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign st_err    = st_err_q;

  assign accept = st_valid && st_ready;
  assign push   = accept && fmt_legal;
  assign pop    = mem_valid && mem_ready;

  assign mem_addr  = {entry_addr_q[rd_ptr_q], 2'b00};
  assign mem_wdata = entry_data_q[rd_ptr_q];
  assign mem_be    = entry_be_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    st_err_d = accept && !fmt_legal;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr_d[i] = entry_addr_q[i];
      entry_data_d[i] = entry_data_q[i];
      entry_be_d[i]   = entry_be_q[i];
    end
    if (push) begin
      entry_addr_d[wr_ptr_q] = st_addr[31:2];
      entry_data_d[wr_ptr_q] = fmt_wdata;
      entry_be_d[wr_ptr_q]   = fmt_be;
      wr_ptr_d               = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_addr_q[i] <= '0;
        entry_data_q[i] <= '0;
        entry_be_q[i]   <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      st_err_q <= st_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_addr_q[i] <= entry_addr_d[i];
        entry_data_q[i] <= entry_data_d[i];
        entry_be_q[i]   <= entry_be_d[i];
      end
    end
  end

  // A slot is occupied when its distance from the head is below the occupancy;
  // the head popping this cycle still counts, since memory has not taken it yet.
  always_comb begin
    hit  = 1'b0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = PW'(i) - rd_ptr_q;
      if (({1'b0, slot} < count_q) && (entry_addr_q[i] == ld_addr[31:2])) begin
        hit = 1'b1;
      end
    end
    ld_hazard = ld_check && hit;
  end

  assign unused_ld_lsbs = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized and directed bench for store_buffer against a queue model
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic [$clog2(DEPTH):0] count;
  logic        empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_funct3 (st_funct3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_err    (st_err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .ld_check  (ld_check),
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard),
    .count     (count),
    .empty     (empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t mq[$];
  bit   m_err;
  int   n_checks;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference formatting from the store rules, using arithmetic rather than bit selects.
  function automatic void fmt(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                              output bit ok, output logic [3:0] be, output logic [31:0] wd);
    ok = 0; be = 0; wd = 0;
    case (f)
      3'd0: begin ok = 1; be = 4'(1 << (a % 4)); wd = (d & 32'hFF) * 32'h01010101; end
      3'd1: begin ok = (a % 2 == 0); be = (a % 4 >= 2) ? 4'hC : 4'h3; wd = (d & 32'hFFFF) * 32'h00010001; end
      3'd2: begin ok = (a % 4 == 0); be = 4'hF; wd = d; end
      default: ok = 0;
    endcase
  endfunction

  task automatic sample();
    bit h;
    #3;
    h = 0;
    foreach (mq[k]) if ((mq[k].addr >> 2) == (ld_addr >> 2)) h = 1;
    check("count", 32'(count), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
    check("mem_valid", 32'(mem_valid), 32'(mq.size() > 0));
    check("st_err", 32'(st_err), 32'(m_err));
    check("ld_hazard", 32'(ld_hazard), 32'(ld_check && h));
    if (mq.size() > 0) begin
      check("mem_addr", mem_addr, mq[0].addr);
      check("mem_wdata", mem_wdata, mq[0].wdata);
      check("mem_be", 32'(mem_be), 32'(mq[0].be));
    end
  endtask

  task automatic advance();
    bit acc, pop, ok;
    ent_t e;
    acc = st_valid && (mq.size() < DEPTH);
    pop = (mq.size() > 0) && mem_ready;
    fmt(st_funct3, st_addr, st_data, ok, e.be, e.wdata);
    e.addr = st_addr - (st_addr % 4);
    if (pop) void'(mq.pop_front());
    m_err = acc && !ok;
    if (acc && ok) mq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    st_valid = v; st_funct3 = f; st_addr = a; st_data = d;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_err = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    mem_ready = 0; ld_check = 1; ld_addr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state; cleared entry at address 0 must not raise a hazard
    sample();
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    advance();
    ld_check = 0;

    // sb at 0x103 with memory ready
    drive(1, 3'b000, 32'h103, 32'hAABBCCDD); mem_ready = 1;
    step();
    drive(0, 0, 0, 0);
    sample();
    check("sb_valid", 32'(mem_valid), 32'h1);
    check("sb_addr", mem_addr, 32'h100);
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hDDDDDDDD);
    advance();
    sample();
    check("sb_count0", 32'(count), 32'h0);
    advance();

    // sh aligned, then misaligned sh
    mem_ready = 0;
    drive(1, 3'b001, 32'h102, 32'h12345678);
    step();
    drive(1, 3'b001, 32'h101, 32'h0000BEEF);
    sample();
    check("sh_be", 32'(mem_be), 32'hC);
    check("sh_wdata", mem_wdata, 32'h56785678);
    advance();
    drive(0, 0, 0, 0);
    sample();
    check("sh_err_pulse", 32'(st_err), 32'h1);
    check("sh_err_count", 32'(count), 32'h1);
    advance();
    sample();
    check("sh_err_clear", 32'(st_err), 32'h0);
    advance();
    mem_ready = 1; step();
    mem_ready = 0; step();

    // fill to full, hold off a fifth store, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'b010, 32'(4 * i), $urandom);
      step();
    end
    drive(1, 3'b010, 32'h10, 32'hCAFEF00D);
    sample();
    check("full_count", 32'(count), 32'h4);
    check("full_ready", 32'(st_ready), 32'h0);
    advance();
    mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("drain_addr", mem_addr, 32'(4 * i));
      if (i == 1) check("fifth_ready", 32'(st_ready), 32'h1);
      advance();
      if (i == 1) drive(0, 0, 0, 0);
    end
    sample();
    check("drain_empty", 32'(empty), 32'h1);
    advance();

    // load hazard against pending sw at 0x20
    mem_ready = 0;
    drive(1, 3'b010, 32'h20, 32'h11223344);
    step();
    drive(0, 0, 0, 0);
    ld_check = 1; ld_addr = 32'h22;
    sample(); check("haz_22", 32'(ld_hazard), 32'h1); advance();
    ld_addr = 32'h24;
    sample(); check("haz_24", 32'(ld_hazard), 32'h0); advance();
    ld_check = 0; mem_ready = 1; step();
    mem_ready = 0; ld_check = 1; ld_addr = 32'h22;
    sample(); check("haz_drained", 32'(ld_hazard), 32'h0); advance();
    ld_check = 0;

    // asynchronous reset with three pending entries and an st_err pulse
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'b010, 32'h30 + 32'(4 * i), $urandom);
      step();
    end
    drive(1, 3'b011, 32'h3C, 32'h0);
    step();
    drive(0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    check("arst_mem_valid", 32'(mem_valid), 32'h0);
    check("arst_count", 32'(count), 32'h0);
    check("arst_st_err", 32'(st_err), 32'h0);
    check("arst_st_ready", 32'(st_ready), 32'h1);
    #1 reset = 1'b0;
    mq.delete(); m_err = 0;
    drive(1, 3'b010, 32'h40, 32'h0BADC0DE);
    step();
    drive(0, 0, 0, 0);
    sample();
    check("post_rst_addr", mem_addr, 32'h40);
    check("post_rst_valid", 32'(mem_valid), 32'h1);
    mem_ready = 1;
    advance();

    // randomized traffic over a small address window to provoke hazards
    for (int c = 0; c < 400; c++) begin
      logic [2:0] f;
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      drive(1'($urandom_range(0, 2) != 0), f, 32'($urandom_range(0, 63)), $urandom);
      mem_ready = 1'($urandom_range(0, 1));
      ld_check  = 1'($urandom_range(0, 1));
      ld_addr   = 32'($urandom_range(0, 63));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write store buffer between the single-cycle core's store path and data memory. It accepts raw sb/sh/sw requests (funct3, byte address, rs2 value) and formats them into word-aligned writes with byte enables and lane-replicated data. It queues them in a DEPTH-entry FIFO and drains them to memory over a valid/ready handshake. It is the write-side counterpart of the core's load-data extraction. It also flags load hazards against pending stores so the core can stall a load that would read stale memory.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- st_valid  in  1  store request present
- st_ready  out  1  buffer can accept (= !full)
- st_funct3  in  3  000 sb, 001 sh, 010 sw; others illegal
- st_addr  in  32  byte address of store
- st_data  in  32  raw rs2 value (data in low bits)
- st_err  out  1  registered one-cycle pulse: previous accepted store was misaligned or illegal funct3
- mem_valid  out  1  head entry valid (= !empty)
- mem_ready  in  1  memory accepts head this cycle
- mem_addr  out  32  word address of head, bits [1:0] = 00
- mem_wdata  out  32  lane-replicated write data of head
- mem_be  out  4  byte enables of head
- ld_check  in  1  core is issuing a load this cycle
- ld_addr  in  32  load byte address
- ld_hazard  out  1  combinational: load hits a pending store word
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Formatting (off = st_addr[1:0]):
  - sb: wdata = {4{st_data[7:0]}}, be = 4'b0001 << off.
  - sh: wdata = {2{st_data[15:0]}}, be = off[1] ? 4'b1100 : 4'b0011; misaligned if off[0] = 1.
  - sw: wdata = st_data, be = 4'b1111; misaligned if off ≠ 00.
  - Stored address = {st_addr[31:2], 2'b00}.
- Accept: handshake = st_valid && st_ready.
  - Legal store: enqueue at write pointer.
  - Misaligned or illegal funct3: handshake completes, nothing is enqueued, and st_err = 1 in the next cycle.
- Drain: on mem_valid && mem_ready, pop head.
  - mem_addr/mem_wdata/mem_be are driven from the head entry.
  - While mem_valid && !mem_ready, these outputs hold stable.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy.
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
- Full: st_ready = 0. There is no pass-through, so st_ready stays 0 even in a cycle where a pop occurs; a new store is accepted the cycle after count drops.
- Empty with a simultaneous push: the entry is written, and mem_valid rises the next cycle. There is no bypass.
- Load hazard:
  - ld_hazard = ld_check && (some occupied entry has addr[31:2] == ld_addr[31:2]).
  - The compare is against whole words, regardless of byte enables.
  - An entry popping in the current cycle still counts as pending.
  - A store being accepted in the current cycle does not count, because the core never issues a store and a load in the same cycle.
- Stores leave in program order. No coalescing.

## Timing
- Reset values: rd_ptr = wr_ptr = 0, count = 0, empty = 1, mem_valid = 0, st_ready = 1, st_err = 0, ld_hazard = 0.
  - Entry contents are don't-care but are cleared to 0 so the mem_* outputs are deterministic.
- Reset asserted mid-operation: all pending entries are discarded immediately (asynchronous). mem_valid drops in the same cycle.
- Latency from an accepted store to mem_valid is 1 cycle. Sustained throughput is 1 store/cycle when mem_ready is held high and the buffer is not full.
- st_err is registered and asserts exactly 1 cycle after the offending handshake, for 1 cycle.
- ld_hazard, st_ready, mem_valid, and empty are combinational from registered state. ld_hazard additionally depends on ld_check and ld_addr.

## Test plan
- Stimulus: sb at 0x103, data 0xAABBCCDD, with mem_ready = 1.
  - Next cycle: mem_valid = 1, mem_addr = 0x100, mem_be = 1000, mem_wdata = 0xDDDDDDDD. count returns to 0 after the pop.
- Stimulus: sh at 0x102, data 0x12345678.
  - Response: mem_be = 1100, mem_wdata = 0x56785678.
  - Then sh at 0x101: accepted, not enqueued, count unchanged, st_err = 1 on the following cycle only.
- Stimulus: with mem_ready = 0, issue 4 sw to 0x0, 0x4, 0x8, 0xC.
  - Response: count = 4, st_ready = 0.
  - A fifth st_valid is held off. Raising mem_ready drains 0x0, 0x4, 0x8, 0xC in order, one per cycle.
  - The fifth store is accepted one cycle after the first pop.
- Stimulus: with an sw to 0x20 pending and mem_ready = 0, assert ld_check at ld_addr 0x22, then at 0x24.
  - Response: ld_hazard = 1 for 0x22, 0 for 0x24. After the entry drains, ld_hazard at 0x22 = 0.
- Stimulus: buffer holds 3 entries with mem_ready = 0; pulse reset asynchronously mid-cycle.
  - Response: mem_valid, count, and st_err go to 0 immediately, and st_ready = 1.
  - After reset, a new sw at 0x40 appears as the first mem_* transaction.
